// File: rtl/aes_ahb_pkg.sv
// Shared definitions for the AES AHB-Lite driver: register map, bus encodings, FSM states.
package aes_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic [31:0] OFS_KEY0   = 32'h00;
  localparam logic [31:0] OFS_PT0    = 32'h10;
  localparam logic [31:0] OFS_CTRL   = 32'h20;
  localparam logic [31:0] OFS_STATUS = 32'h24;
  localparam logic [31:0] OFS_CT0    = 32'h28;

  typedef enum logic [2:0] {
    StIdle,
    StWrKey,
    StWrPt,
    StWrCtrl,
    StPoll,
    StRdCt,
    StFault
  } aes_state_e;

  // Word n of a 128-bit value is bits [32n+31:32n].
  function automatic logic [31:0] get_word(input logic [127:0] v, input logic [1:0] i);
    logic [31:0] w;
    case (i)
      2'd0:    w = v[31:0];
      2'd1:    w = v[63:32];
      2'd2:    w = v[95:64];
      default: w = v[127:96];
    endcase
    return w;
  endfunction

  function automatic logic [127:0] set_word(input logic [127:0] v, input logic [1:0] i,
                                            input logic [31:0] w);
    logic [127:0] r;
    r = v;
    case (i)
      2'd0:    r[31:0]   = w;
      2'd1:    r[63:32]  = w;
      2'd2:    r[95:64]  = w;
      default: r[127:96] = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ahb_mst_xfer.sv
// Single non-overlapped AHB-Lite transfer engine: one address phase, then one data phase.
module ahb_mst_xfer
  import aes_ahb_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        write,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  logic        data_q;
  logic [31:0] haddr_q;
  logic        hwrite_q;
  logic [31:0] hwdata_q;
  logic        addr_phase;

  // An address phase is presented whenever a request is pending and no data phase is open.
  assign addr_phase = req && !data_q;

  // Phase tracking plus held copies of the address/control and write data.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      data_q   <= 1'b0;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hwdata_q <= '0;
    end else begin
      if (addr_phase) begin
        haddr_q  <= addr;
        hwrite_q <= write;
      end
      if (addr_phase && HREADY) begin
        data_q <= 1'b1;
        if (write) hwdata_q <= wdata;
      end else if (data_q && (HREADY || HRESP)) begin
        // An error response ends the transfer on its first cycle; the job aborts anyway.
        data_q <= 1'b0;
      end
    end
  end

  // Bus drive: live address during the address phase, held values otherwise.
  always_comb begin
    HTRANS = addr_phase ? HTRANS_NONSEQ : HTRANS_IDLE;
    HADDR  = addr_phase ? addr : haddr_q;
    HWRITE = addr_phase ? write : hwrite_q;
    HSIZE  = HSIZE_WORD;
    HWDATA = hwdata_q;
    ack    = data_q && (HREADY || HRESP);
    err    = data_q && HRESP;
    rdata  = HRDATA;
  end

endmodule

// File: rtl/aes_ahb_driver.sv
// AHB-Lite manager that loads key/plaintext into an AES peripheral, starts it,
// polls for completion and reads back the ciphertext.
module aes_ahb_driver
  import aes_ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned POLL_MAX  = 1024
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] plaintext_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         error_o,
  output logic [127:0] ciphertext_o,
  output logic [31:0]  HADDR,
  output logic [1:0]   HTRANS,
  output logic         HWRITE,
  output logic [2:0]   HSIZE,
  output logic [31:0]  HWDATA,
  input  logic [31:0]  HRDATA,
  input  logic         HREADY,
  input  logic         HRESP
);

  localparam int unsigned PW = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] POLL_LIM = PW'(POLL_MAX);

  aes_state_e     state_q, state_d;
  logic [1:0]     idx_q, idx_d;
  logic [PW-1:0]  poll_q, poll_d, poll_inc;
  logic [127:0]   key_q, key_d, pt_q, pt_d, ct_q, ct_d;
  logic           done_q, done_d, error_q, error_d;

  logic           req, write, ack, err;
  logic [31:0]    addr, wdata, rdata;

  ahb_mst_xfer u_xfer (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .req    (req),
    .addr   (addr),
    .write  (write),
    .wdata  (wdata),
    .ack    (ack),
    .rdata  (rdata),
    .err    (err),
    .HADDR  (HADDR),
    .HTRANS (HTRANS),
    .HWRITE (HWRITE),
    .HSIZE  (HSIZE),
    .HWDATA (HWDATA),
    .HRDATA (HRDATA),
    .HREADY (HREADY),
    .HRESP  (HRESP)
  );

  assign poll_inc = (poll_q == POLL_LIM) ? poll_q : poll_q + PW'(1);

  // State, job operands and result registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
      idx_q   <= '0;
      poll_q  <= '0;
      key_q   <= '0;
      pt_q    <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      poll_q  <= poll_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      ct_q    <= ct_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // Sequencer: issues one transfer request per step and advances on its acknowledge.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    poll_d  = poll_q;
    key_d   = key_q;
    pt_d    = pt_q;
    ct_d    = ct_q;
    done_d  = 1'b0;
    error_d = error_q;
    req     = 1'b0;
    write   = 1'b0;
    addr    = BASE_ADDR;
    wdata   = '0;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          key_d   = key_i;
          pt_d    = plaintext_i;
          error_d = 1'b0;
          poll_d  = '0;
          idx_d   = '0;
          state_d = StWrKey;
        end
      end
      StWrKey, StWrPt: begin
        req   = 1'b1;
        write = 1'b1;
        if (state_q == StWrKey) begin
          addr  = BASE_ADDR + OFS_KEY0 + {28'b0, idx_q, 2'b00};
          wdata = get_word(key_q, idx_q);
        end else begin
          addr  = BASE_ADDR + OFS_PT0 + {28'b0, idx_q, 2'b00};
          wdata = get_word(pt_q, idx_q);
        end
        if (ack) begin
          if (err) begin
            state_d = StFault;
          end else if (idx_q == 2'd3) begin
            idx_d   = '0;
            state_d = (state_q == StWrKey) ? StWrPt : StWrCtrl;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      StWrCtrl: begin
        req   = 1'b1;
        write = 1'b1;
        addr  = BASE_ADDR + OFS_CTRL;
        wdata = 32'h1;
        if (ack) state_d = err ? StFault : StPoll;
      end
      StPoll: begin
        req  = 1'b1;
        addr = BASE_ADDR + OFS_STATUS;
        if (ack) begin
          if (err) begin
            state_d = StFault;
          end else if (rdata[0]) begin
            idx_d   = '0;
            state_d = StRdCt;
          end else begin
            poll_d = poll_inc;
            if (poll_inc == POLL_LIM) state_d = StFault;
          end
        end
      end
      StRdCt: begin
        req  = 1'b1;
        addr = BASE_ADDR + OFS_CT0 + {28'b0, idx_q, 2'b00};
        if (ack) begin
          if (err) begin
            state_d = StFault;
          end else begin
            ct_d = set_word(ct_q, idx_q, rdata);
            if (idx_q == 2'd3) begin
              idx_d   = '0;
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
      end
      StFault: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Every abort path lands in FAULT with the sticky flag raised.
    if (state_d == StFault && state_q != StFault) begin
      error_d = 1'b1;
      idx_d   = '0;
    end
  end

  assign busy_o       = (state_q != StIdle) && (state_q != StFault);
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign ciphertext_o = ct_q;

endmodule

// File: tb/tb_aes_ahb_driver.sv
// Directed bench for aes_ahb_driver with a behavioural AHB-Lite AES slave.
module tb_aes_ahb_driver;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  int checks = 0;
  int errors = 0;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] pt = '0;

  always #5 HCLK = ~HCLK;

  // Two DUTs: default parameters (a) and POLL_MAX=4 (b); sel picks which one owns the slave.
  logic a_busy, a_done, a_err, a_hwrite, b_busy, b_done, b_err, b_hwrite;
  logic [127:0] a_ct, b_ct;
  logic [31:0] a_haddr, a_hwdata, b_haddr, b_hwdata;
  logic [1:0] a_htrans, b_htrans;
  logic [2:0] a_hsize, b_hsize;
  logic s_hready, s_hresp;
  logic [31:0] s_rdata;

  aes_ahb_driver u_dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .start_i(start && !sel), .key_i(key), .plaintext_i(pt),
    .busy_o(a_busy), .done_o(a_done), .error_o(a_err), .ciphertext_o(a_ct),
    .HADDR(a_haddr), .HTRANS(a_htrans), .HWRITE(a_hwrite), .HSIZE(a_hsize), .HWDATA(a_hwdata),
    .HRDATA(s_rdata), .HREADY(sel ? 1'b1 : s_hready), .HRESP(sel ? 1'b0 : s_hresp)
  );

  aes_ahb_driver #(.BASE_ADDR(BASE), .POLL_MAX(4)) u_dut_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .start_i(start && sel), .key_i(key), .plaintext_i(pt),
    .busy_o(b_busy), .done_o(b_done), .error_o(b_err), .ciphertext_o(b_ct),
    .HADDR(b_haddr), .HTRANS(b_htrans), .HWRITE(b_hwrite), .HSIZE(b_hsize), .HWDATA(b_hwdata),
    .HRDATA(s_rdata), .HREADY(sel ? s_hready : 1'b1), .HRESP(sel ? s_hresp : 1'b0)
  );

  wire        busy    = sel ? b_busy : a_busy;
  wire        done    = sel ? b_done : a_done;
  wire        err_o   = sel ? b_err : a_err;
  wire [127:0] ct     = sel ? b_ct : a_ct;
  wire [31:0] m_haddr = sel ? b_haddr : a_haddr;
  wire [31:0] m_hwdata = sel ? b_hwdata : a_hwdata;
  wire [1:0]  m_htrans = sel ? b_htrans : a_htrans;
  wire        m_hwrite = sel ? b_hwrite : a_hwrite;
  wire [2:0]  m_hsize  = sel ? b_hsize : a_hsize;

  // Slave configuration (written only by the test tasks).
  int waits = 0;
  int status_zeros = 0;
  int status_base = 0;
  logic err_en = 1'b0;
  logic [31:0] err_addr = '0;

  // Slave state and logs (written only by the slave process).
  logic dp_valid, dp_write, dp_first;
  logic [31:0] dp_addr, dp_wd;
  int wait_cnt;
  int nonseq_cnt = 0, status_total = 0, ct_reads = 0, stab_errs = 0;
  logic [31:0] key0_wdata = '0;
  logic [31:0] addr_log [0:255];

  assign s_hready = !(dp_valid && wait_cnt != 0);
  assign s_hresp  = dp_valid && err_en && (dp_addr == err_addr);

  always_comb begin
    s_rdata = '0;
    if (dp_valid && !dp_write) begin
      case (dp_addr - BASE)
        32'h24: s_rdata = {31'b0, (status_total - status_base) >= status_zeros};
        32'h28: s_rdata = FIPS_CT[31:0];
        32'h2C: s_rdata = FIPS_CT[63:32];
        32'h30: s_rdata = FIPS_CT[95:64];
        32'h34: s_rdata = FIPS_CT[127:96];
        default: s_rdata = 32'h0;
      endcase
    end
  end

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_first <= 1'b0;
      dp_addr  <= '0;
      dp_wd    <= '0;
      wait_cnt <= 0;
    end else begin
      if (dp_valid) begin
        if (m_htrans != 2'b00 || m_haddr != dp_addr || m_hwrite != dp_write)
          stab_errs <= stab_errs + 1;
        if (dp_write) begin
          dp_first <= 1'b0;
          if (dp_first) dp_wd <= m_hwdata;
          else if (m_hwdata != dp_wd) stab_errs <= stab_errs + 1;
        end
        if (s_hready) begin
          dp_valid <= 1'b0;
          if (dp_write && dp_addr == BASE) key0_wdata <= m_hwdata;
          if (!dp_write && dp_addr == BASE + 32'h24) status_total <= status_total + 1;
          if (!dp_write && dp_addr >= BASE + 32'h28 && dp_addr <= BASE + 32'h34)
            ct_reads <= ct_reads + 1;
        end else begin
          wait_cnt <= wait_cnt - 1;
        end
      end
      if (m_htrans == 2'b10 && s_hready) begin
        dp_valid <= 1'b1;
        dp_addr  <= m_haddr;
        dp_write <= m_hwrite;
        dp_first <= 1'b1;
        wait_cnt <= waits;
        addr_log[nonseq_cnt % 256] <= m_haddr;
        nonseq_cnt <= nonseq_cnt + 1;
      end
    end
  end

  // Pulses start for one cycle (cycle 0) and tracks the job until busy falls.
  task automatic run_job(input int max_cyc, output int done_cyc, output bit saw_done,
                         output bit timeout);
    done_cyc = -1;
    saw_done = 1'b0;
    timeout  = 1'b1;
    @(negedge HCLK);
    status_base = status_total;
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    for (int n = 1; n <= max_cyc; n++) begin
      if (done) begin
        saw_done = 1'b1;
        done_cyc = n;
      end
      if (!busy) begin
        timeout = 1'b0;
        break;
      end
      @(negedge HCLK);
    end
    checks++;
    if (timeout) begin
      errors++;
      $display("FAIL job_timeout: busy still %0b after %0d cycles, required 0", busy, max_cyc);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (m_htrans !== 2'b00 || m_haddr !== 32'h0 || m_hwrite !== 1'b0 || m_hsize !== 3'b010 ||
        m_hwdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: htrans=%h haddr=%h hwrite=%b hsize=%b hwdata=%h, required 0/0/0/2/0",
               m_htrans, m_haddr, m_hwrite, m_hsize, m_hwdata);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err_o !== 1'b0 || ct !== 128'h0) begin
      errors++;
      $display("FAIL reset_user: busy=%b done=%b error=%b ct=%h, required 0/0/0/0",
               busy, done, err_o, ct);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
    checks++;
    if (nonseq_cnt !== 0 || m_htrans !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: nonseq=%0d htrans=%h, required 0 and 0", nonseq_cnt, m_htrans);
    end
  endtask

  task automatic test_fips();
    int dc; bit sd, to;
    sel = 1'b0; waits = 0; status_zeros = 0; err_en = 1'b0;
    key = FIPS_KEY; pt = FIPS_PT;
    run_job(200, dc, sd, to);
    checks++;
    if (ct !== FIPS_CT) begin
      errors++; $display("FAIL fips_ct: got %h, required %h", ct, FIPS_CT);
    end
    checks++;
    if (!sd || dc != 29) begin
      errors++; $display("FAIL fips_done_cycle: got %0d (seen %0b), required 29", dc, sd);
    end
    checks++;
    if (key0_wdata !== 32'h0c0d0e0f) begin
      errors++; $display("FAIL fips_key0: got %h, required 0c0d0e0f", key0_wdata);
    end
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL fips_error: got %b, required 0", err_o);
    end
  endtask

  task automatic test_wait_states();
    int dc; bit sd, to; int s0;
    waits = 3; s0 = stab_errs;
    run_job(400, dc, sd, to);
    checks++;
    if (ct !== FIPS_CT) begin
      errors++; $display("FAIL wait_ct: got %h, required %h", ct, FIPS_CT);
    end
    checks++;
    if (!sd || dc != 29 + 14 * 3) begin
      errors++; $display("FAIL wait_done_cycle: got %0d, required %0d", dc, 29 + 14 * 3);
    end
    checks++;
    if (stab_errs != s0) begin
      errors++; $display("FAIL wait_stable: %0d unstable cycles, required 0", stab_errs - s0);
    end
    waits = 0;
  endtask

  task automatic test_poll_retry();
    int dc; bit sd, to; int s0, c0;
    status_zeros = 5; s0 = status_total; c0 = ct_reads;
    run_job(400, dc, sd, to);
    checks++;
    if (status_total - s0 != 6) begin
      errors++; $display("FAIL poll_reads: got %0d, required 6", status_total - s0);
    end
    checks++;
    if (ct_reads - c0 != 4) begin
      errors++; $display("FAIL poll_ct_reads: got %0d, required 4", ct_reads - c0);
    end
    checks++;
    if (!sd || err_o !== 1'b0) begin
      errors++; $display("FAIL poll_done: done_seen=%0b error=%b, required 1/0", sd, err_o);
    end
    status_zeros = 0;
  endtask

  task automatic test_hresp_fault();
    int dc; bit sd, to; int n0;
    err_en = 1'b1; err_addr = BASE + 32'h14; n0 = nonseq_cnt;
    run_job(200, dc, sd, to);
    repeat (5) @(negedge HCLK);
    checks++;
    if (nonseq_cnt - n0 != 6) begin
      errors++; $display("FAIL fault_nonseq: got %0d transfers, required 6", nonseq_cnt - n0);
    end
    checks++;
    if (err_o !== 1'b1 || sd || busy !== 1'b0) begin
      errors++; $display("FAIL fault_flags: error=%b done_seen=%0b busy=%b, required 1/0/0",
                         err_o, sd, busy);
    end
    err_en = 1'b0;
  endtask

  task automatic test_poll_timeout();
    int dc; bit sd, to; int s0;
    sel = 1'b1; status_zeros = 1000; s0 = status_total;
    run_job(400, dc, sd, to);
    checks++;
    if (status_total - s0 != 4) begin
      errors++; $display("FAIL timeout_reads: got %0d, required 4", status_total - s0);
    end
    checks++;
    if (err_o !== 1'b1 || sd) begin
      errors++; $display("FAIL timeout_error: error=%b done_seen=%0b, required 1/0", err_o, sd);
    end
    status_zeros = 0;
    run_job(200, dc, sd, to);
    checks++;
    if (err_o !== 1'b0 || !sd || ct !== FIPS_CT) begin
      errors++; $display("FAIL timeout_recover: error=%b done_seen=%0b ct=%h, required 0/1/%h",
                         err_o, sd, ct, FIPS_CT);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_job();
    int dc; bit sd, to; bit hit; int n0;
    sel = 1'b0; waits = 10; hit = 1'b0;
    @(negedge HCLK); start = 1'b1;
    @(negedge HCLK); start = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (dp_valid && dp_addr == BASE + 32'h10 && wait_cnt < 8) begin
        hit = 1'b1;
        break;
      end
      @(negedge HCLK);
    end
    checks++;
    if (!hit || s_hready !== 1'b0) begin
      errors++; $display("FAIL midrst_reach: reached=%0b hready=%b, required 1/0", hit, s_hready);
    end
    HRESETn = 1'b0;
    #1;
    checks++;
    if (m_htrans !== 2'b00 || m_haddr !== 32'h0 || m_hwrite !== 1'b0 || m_hsize !== 3'b010 ||
        m_hwdata !== 32'h0) begin
      errors++;
      $display("FAIL midrst_bus: htrans=%h haddr=%h hwrite=%b hsize=%b hwdata=%h, required 0/0/0/2/0",
               m_htrans, m_haddr, m_hwrite, m_hsize, m_hwdata);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err_o !== 1'b0 || ct !== 128'h0) begin
      errors++;
      $display("FAIL midrst_user: busy=%b done=%b error=%b ct=%h, required 0/0/0/0",
               busy, done, err_o, ct);
    end
    waits = 0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    n0 = nonseq_cnt;
    run_job(200, dc, sd, to);
    checks++;
    if (addr_log[n0 % 256] !== BASE || nonseq_cnt - n0 != 14) begin
      errors++; $display("FAIL midrst_restart: first addr %h, %0d transfers, required %h and 14",
                         addr_log[n0 % 256], nonseq_cnt - n0, BASE);
    end
    checks++;
    if (ct !== FIPS_CT || !sd || dc != 29) begin
      errors++; $display("FAIL midrst_job: ct=%h done_cycle=%0d, required %h and 29",
                         ct, dc, FIPS_CT);
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_wait_states();
    test_poll_retry();
    test_hresp_fault();
    test_poll_timeout();
    test_reset_mid_job();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
